// File: rtl/systolic_pkg.sv
// Shared types and requantization arithmetic for the systolic array output path.
package systolic_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_MATRIX_SIZE = 8;
   localparam int DEF_ACC_WIDTH   = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      FLUSH = 3'd2,
      CLEAR = 3'd3,
      DONE  = 3'd4
   } drain_state_t;

   // Round-half-up, arithmetic shift, optional ReLU, saturate to data_width bits.
   // Works on a 64-bit signed carrier so the rounding add never wraps for accumulators up to 63 bits.
   function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                  input logic [7:0]         shift,
                                                  input logic               relu,
                                                  input int                 data_width);
      logic signed [63:0] x;
      logic signed [63:0] y;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      x  = (shift != 8'd0) ? (acc + (64'sd1 <<< (shift - 8'd1))) : acc;
      y  = x >>> shift;
      hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (relu && (y < 64'sd0)) begin
         y = 64'sd0;
      end else begin
         y = y;
      end
      if (y > hi) begin
         y = hi;
      end else if (y < lo) begin
         y = lo;
      end else begin
         y = y;
      end
      return y;
   endfunction

endpackage

// File: rtl/requant_unit.sv
// Pure combinational requantizer: ACC_WIDTH signed accumulator to DATA_WIDTH signed element.
module requant_unit
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
   input  logic signed [ACC_WIDTH-1:0]   acc,
   input  logic        [SHIFT_WIDTH-1:0] shift,
   input  logic                          relu,
   output logic signed [DATA_WIDTH-1:0]  q
);

   assign q = DATA_WIDTH'(requant(64'(acc), 8'(shift), relu, DATA_WIDTH));

endmodule

// File: rtl/systolic_drain.sv
// Scans the systolic accumulators row-major, requantizes each one and streams it over valid/ready,
// optionally pulsing acc_rst once the final beat has been accepted.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
   parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
   parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
   parameter int SHIFT_WIDTH    = $clog2(ACC_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic        [SHIFT_WIDTH-1:0] shift_amt,
   input  logic                          relu_en,
   input  logic                          clear_en,
   output logic     [ACC_ADDR_WIDTH-1:0] addr_acc,
   input  logic signed  [ACC_WIDTH-1:0]  acc_out,
   output logic                          acc_rst,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic     [ACC_ADDR_WIDTH-1:0] out_index,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done
);

   localparam int N = MATRIX_SIZE * MATRIX_SIZE;
   localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX = ACC_ADDR_WIDTH'(N - 1);

   drain_state_t                   state_r;
   drain_state_t                   state_next_s;
   logic [SHIFT_WIDTH-1:0]         shift_r;
   logic                           relu_r;
   logic                           clear_r;
   logic                           cap_s;
   logic                           hs_s;
   logic signed [DATA_WIDTH-1:0]   q_s;

   // A new element may enter the output register whenever it is empty or being emptied this cycle.
   assign cap_s = (state_r == DRAIN) && (!out_valid || out_ready);
   assign hs_s  = out_valid && out_ready;

   requant_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_requant (
      .acc   (acc_out),
      .shift (shift_r),
      .relu  (relu_r),
      .q     (q_s)
   );

   // Next-state logic for the drain sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = IDLE;
            end
         end
         DRAIN: begin
            if (cap_s && (addr_acc == LAST_IDX)) begin
               state_next_s = FLUSH;
            end else begin
               state_next_s = DRAIN;
            end
         end
         FLUSH: begin
            if (hs_s) begin
               state_next_s = clear_r ? CLEAR : DONE;
            end else begin
               state_next_s = FLUSH;
            end
         end
         CLEAR:   state_next_s = DONE;
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register and configuration captured on an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         shift_r <= {SHIFT_WIDTH{1'b0}};
         relu_r  <= 1'b0;
         clear_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         if ((state_r == IDLE) && start) begin
            shift_r <= shift_amt;
            relu_r  <= relu_en;
            clear_r <= clear_en;
         end
      end
   end

   // Output register stage and accumulator scan address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_acc  <= {ACC_ADDR_WIDTH{1'b0}};
         out_valid <= 1'b0;
         out_data  <= {DATA_WIDTH{1'b0}};
         out_index <= {ACC_ADDR_WIDTH{1'b0}};
         out_last  <= 1'b0;
      end else if (cap_s) begin
         out_data  <= q_s;
         out_index <= addr_acc;
         out_last  <= (addr_acc == LAST_IDX);
         out_valid <= 1'b1;
         addr_acc  <= (addr_acc == LAST_IDX) ? {ACC_ADDR_WIDTH{1'b0}}
                                              : (addr_acc + ACC_ADDR_WIDTH'(1));
      end else if (hs_s) begin
         out_valid <= 1'b0;
      end
   end

   // Status flags registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         acc_rst <= 1'b0;
      end else begin
         busy    <= (state_next_s != IDLE);
         done    <= (state_next_s == DONE);
         acc_rst <= (state_next_s == CLEAR);
      end
   end

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized bench for systolic_drain: a behavioural stream model checked every cycle on the falling edge.
module tb_systolic_drain;

   localparam int N = 64;

   logic               clk;
   logic               rst;
   logic               start;
   logic [4:0]         shift_amt;
   logic               relu_en;
   logic               clear_en;
   logic [5:0]         addr_acc;
   logic signed [31:0] acc_out;
   logic               acc_rst;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic [5:0]         out_index;
   logic               out_last;
   logic               busy;
   logic               done;

   logic signed [31:0] acc_mem [N];
   longint             exp_q   [N];
   longint             cap_data[N];

   int     n_cmp = 0;
   int     n_fail = 0;
   int     exp_idx = 0;
   int     cyc_n = 0;
   int     hs_cyc = -100;
   int     done_cnt = 0;
   bit     exp_clr = 1'b0;
   bit     mon_en = 1'b0;
   bit     rdy_rand = 1'b0;
   bit     prev_stall = 1'b0;
   longint prev_data = 0;
   longint prev_index = 0;

   systolic_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .shift_amt (shift_amt),
      .relu_en   (relu_en),
      .clear_en  (clear_en),
      .addr_acc  (addr_acc),
      .acc_out   (acc_out),
      .acc_rst   (acc_rst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   assign acc_out = acc_mem[addr_acc];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Floor division by 2^s written out explicitly, then ReLU and int8 saturation.
   function automatic longint q_model(input longint acc, input int s, input bit relu);
      longint x, p, y;
      x = acc;
      if (s > 0) x = x + (longint'(1) << (s - 1));
      p = longint'(1) << s;
      y = x / p;
      if (x < 0 && y * p != x) y = y - 1;
      if (relu && y < 0) y = 0;
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      return y;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Per-cycle compare: handshaked beats, stall stability, acc_rst/done timing, idle address.
   always @(negedge clk) begin
      if (rst && mon_en) begin
         cyc_n++;
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_index", out_index, prev_index);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_index = out_index;
         check("acc_rst", acc_rst, (exp_clr && cyc_n == hs_cyc + 1) ? 1 : 0);
         check("done", done, (cyc_n == hs_cyc + (exp_clr ? 2 : 1)) ? 1 : 0);
         if (!busy) check("addr_idle", addr_acc, 0);
         if (out_valid) check("busy_valid", busy, 1);
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            if (exp_idx >= N) begin
               check("extra_beat", exp_idx, N - 1);
            end else begin
               check("index", out_index, exp_idx);
               check("data", out_data, exp_q[exp_idx]);
               check("last", out_last, (exp_idx == N - 1) ? 1 : 0);
               cap_data[exp_idx] = out_data;
               if (exp_idx == N - 1) hs_cyc = cyc_n;
               exp_idx++;
            end
         end
      end
   end

   task automatic run_start(input int s, input bit rl, input bit cl);
      for (int i = 0; i < N; i++) exp_q[i] = q_model(acc_mem[i], s, rl);
      exp_idx    = 0;
      exp_clr    = cl;
      hs_cyc     = -100;
      prev_stall = 1'b0;
      shift_amt  = 5'(s);
      relu_en    = rl;
      clear_en   = cl;
      start      = 1'b1;
      step();
      start      = 1'b0;
      shift_amt  = 5'($urandom);
      relu_en    = 1'($urandom);
      clear_en   = 1'($urandom);
   endtask

   task automatic wait_done(input string nm);
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < 3000 && done_cnt == d0; k++) step();
      repeat (5) step();
      check({nm, "_one_done"}, done_cnt - d0, 1);
      check({nm, "_beats"}, exp_idx, N);
   endtask

   task automatic wait_beat(input int n);
      for (int k = 0; k < 3000 && exp_idx < n; k++) step();
      check("beat_reached", (exp_idx >= n) ? 1 : 0, 1);
   endtask

   task automatic check_zero(input string nm);
      check({nm, "_addr"}, addr_acc, 0);
      check({nm, "_acc_rst"}, acc_rst, 0);
      check({nm, "_valid"}, out_valid, 0);
      check({nm, "_data"}, out_data, 0);
      check({nm, "_index"}, out_index, 0);
      check({nm, "_last"}, out_last, 0);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_done"}, done, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 1) == 0) acc_mem[i] = $urandom;
         else acc_mem[i] = 32'($signed($urandom_range(0, 8191)) - 4096);
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      shift_amt = 5'd0;
      relu_en = 1'b0;
      clear_en = 1'b0;
      for (int i = 0; i < N; i++) acc_mem[i] = 32'(i);
      repeat (3) step();
      check_zero("reset");
      rst = 1'b1;
      mon_en = 1'b1;
      step();

      // Ramp at full throughput.
      run_start(0, 1'b0, 1'b0);
      check("busy_after_start", busy, 1);
      step();
      check("first_valid", out_valid, 1);
      check("first_index", out_index, 0);
      wait_done("ramp");
      check("ramp_last", cap_data[63], 63);
      check("ramp_mid", cap_data[10], 10);

      // Requant corner values with backpressure and clear.
      fill_random();
      acc_mem[0] = 32'sd1000;
      acc_mem[1] = -32'sd1000;
      acc_mem[2] = 32'sd5000;
      acc_mem[3] = -32'sd5000;
      rdy_rand = 1'b1;
      run_start(3, 1'b0, 1'b1);
      wait_done("requant");
      check("rq_pos", cap_data[0], 125);
      check("rq_neg", cap_data[1], -125);
      check("rq_sat_hi", cap_data[2], 127);
      check("rq_sat_lo", cap_data[3], -128);

      run_start(3, 1'b1, 1'b0);
      wait_done("relu");
      check("relu_neg", cap_data[1], 0);
      check("relu_pos", cap_data[0], 125);

      // Random configurations; one run has a stray start mid-stream.
      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_start($urandom_range(0, 12), 1'($urandom), 1'($urandom));
         if (r == 1) begin
            wait_beat(20);
            start = 1'b1;
            step();
            start = 1'b0;
         end
         wait_done("random");
      end

      // Reset in the middle of a drain, then a fresh drain from index 0.
      for (int i = 0; i < N; i++) acc_mem[i] = 32'(i * 3 - 90);
      run_start(1, 1'b0, 1'b1);
      wait_beat(30);
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      check_zero("reset_edge");
      step();
      rst = 1'b1;
      mon_en = 1'b1;
      step();
      run_start(0, 1'b0, 1'b0);
      step();
      check("restart_index", out_index, 0);
      wait_done("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
